// File: rtl/cache_port_arbiter_if.sv
// Bundle of requester-side and cache-side signals for cache_port_arbiter.
// The master modport is the environment view; the slave modport is the arbiter view.
interface cache_port_arbiter_if;
  logic        i_req;
  logic [27:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_rw;
  logic [27:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        flush_req;
  logic        flush_ack;

  logic [27:0] cache_addr;
  logic [31:0] cache_wr;
  logic        cache_rw;
  logic        cache_valid;
  logic        flush;
  logic [31:0] cache_rd;
  logic        cache_ready;

  logic        arb_timeout;

  modport master (
    output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, flush_req, cache_rd, cache_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, flush_ack,
    input  cache_addr, cache_wr, cache_rw, cache_valid, flush, arb_timeout
  );

  modport slave (
    input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, flush_req, cache_rd, cache_ready,
    output i_ack, i_rdata, d_ack, d_rdata, flush_ack,
    output cache_addr, cache_wr, cache_rw, cache_valid, flush, arb_timeout
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Arbitrates instruction, data and flush requesters onto a single cache port with a timeout.
// Define CACHE_ARB_ROUND_ROBIN_EN to replace fixed data-over-instruction priority with round-robin.
module cache_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  cache_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, FLUSH, ACK} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_D, OWN_F} owner_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  owner_t      owner;
  logic [7:0]  timer;
  logic [27:0] addr_q;
  logic [31:0] wr_q;
  logic        rw_q;
  logic        valid_q;
  logic        flush_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic        flush_ack_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        timeout_q;
  logic        grant_d;
  logic        finish;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // last_d=0 means instruction was granted last, so data wins the first tie.
  logic last_d;

  always_comb grant_d = bus.d_req && (!bus.i_req || !last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && !bus.flush_req && (bus.d_req || bus.i_req)) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb grant_d = bus.d_req;
`endif

  always_comb finish = bus.cache_ready || (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_I;
      timer       <= '0;
      addr_q      <= '0;
      wr_q        <= '0;
      rw_q        <= 1'b0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      flush_ack_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      flush_ack_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (bus.flush_req) begin
            state   <= FLUSH;
            owner   <= OWN_F;
            flush_q <= 1'b1;
          end else if (bus.d_req || bus.i_req) begin
            state   <= ACCESS;
            valid_q <= 1'b1;
            if (grant_d) begin
              owner  <= OWN_D;
              addr_q <= bus.d_addr;
              wr_q   <= bus.d_wdata;
              rw_q   <= bus.d_rw;
            end else begin
              owner  <= OWN_I;
              addr_q <= bus.i_addr;
              wr_q   <= '0;
              rw_q   <= 1'b0;
            end
          end
        end
        ACCESS, FLUSH: begin
          if (finish) begin
            // A timed-out read returns zero so the requester never sees stale data.
            state     <= ACK;
            valid_q   <= 1'b0;
            flush_q   <= 1'b0;
            timeout_q <= !bus.cache_ready;
            case (owner)
              OWN_D: begin
                d_ack_q   <= 1'b1;
                d_rdata_q <= bus.cache_ready ? bus.cache_rd : 32'h0;
              end
              OWN_I: begin
                i_ack_q   <= 1'b1;
                i_rdata_q <= bus.cache_ready ? bus.cache_rd : 32'h0;
              end
              default: flush_ack_q <= 1'b1;
            endcase
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cache_addr  = addr_q;
  assign bus.cache_wr    = wr_q;
  assign bus.cache_rw    = rw_q;
  assign bus.cache_valid = valid_q;
  assign bus.flush       = flush_q;
  assign bus.i_ack       = i_ack_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.flush_ack   = flush_ack_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.arb_timeout = timeout_q;

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles an access waits in ACCESS/FLUSH for cache_ready before it is aborted (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports i_req input 1, i_addr input 28, i_ack output 1, i_rdata output 32: instruction requester, read-only.
REQ-005 SHALL have ports d_req input 1, d_rw input 1 (1=write), d_addr input 28, d_wdata input 32, d_ack output 1, d_rdata output 32: data requester.
REQ-006 SHALL have ports flush_req input 1, flush_ack output 1: flush requester.
REQ-007 SHALL have ports cache_addr output 28, cache_wr output 32, cache_rw output 1, cache_valid output 1, flush output 1: cache request side.
REQ-008 SHALL have ports cache_rd input 32, cache_ready input 1: cache response side.
REQ-009 SHALL have port arb_timeout output 1: one-cycle pulse when an access is aborted.

Function
REQ-010 SHALL implement states IDLE, ACCESS, FLUSH, ACK.
REQ-011 IDLE: flush_req -> FLUSH; else d_req or i_req -> ACCESS per priority (REQ-020); else stay.
REQ-012 On IDLE->ACCESS, SHALL latch owner, address, write data (0 for instruction) and rw (0 for instruction) into registers driving cache_addr/cache_wr/cache_rw.
REQ-013 ACCESS: cache_valid=1 every cycle; cache_addr/cache_wr/cache_rw constant; requester inputs ignored.
REQ-014 ACCESS with cache_ready=1: SHALL capture cache_rd into owner's rdata register (also on writes) and go to ACK.
REQ-015 FLUSH: flush=1, cache_valid=0; cache_ready=1 -> ACK.
REQ-016 ACK: cache_valid=0, flush=0; exactly one of i_ack/d_ack/flush_ack high for this single cycle, selected by owner; next state IDLE.
REQ-017 Latency: grant registered in cycle N drives cache_valid from N+1; cache_ready at cycle M gives ack at M+1; minimum request-to-ack 3 cycles.
REQ-018 Requester SHALL hold req and inputs stable until its ack; req still high in the IDLE cycle after ack is a new request (back-to-back legal, one idle cycle between accesses).
REQ-019 A flush_req arriving during ACCESS SHALL wait; no access is ever preempted.
REQ-020 Priority: flush > data > instruction (see REQ-027 for alternative).
REQ-021 Timeout counter SHALL clear on entry to ACCESS/FLUSH and increment each cycle there; reaching TIMEOUT_CYCLES without cache_ready -> ACK with owner rdata = 32'h0 and arb_timeout=1 in the ACK cycle.
REQ-022 cache_ready in IDLE or ACK SHALL be ignored.
REQ-023 i_rdata/d_rdata SHALL hold last captured value until the same owner's next completion.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, zero the timeout counter and drive every output to 0 (cache_addr, cache_wr, cache_rw, cache_valid, flush, all acks, i_rdata, d_rdata, arb_timeout).
REQ-025 Reset mid-ACCESS/FLUSH SHALL abandon the access with no ack; after release, arbitration restarts in IDLE.
REQ-026 Round-robin pointer (when compiled) SHALL reset to "instruction last granted" (data wins first tie).

Configuration
REQ-027 Macro CACHE_ARB_ROUND_ROBIN_EN defined: flush still highest; between i_req and d_req, the requester not granted last wins a tie; pointer updates on every I/D grant.
REQ-028 Macro undefined: fixed priority per REQ-020, no pointer register.

Verification
REQ-029 d_req=1,d_rw=1,d_addr=28'h000_1018,d_wdata=32'h6666_7777; cache_ready 4 cycles after cache_valid -> cache_valid high 4 cycles with cache_wr=32'h6666_7777, cache_rw=1, d_ack pulse next cycle.
REQ-030 i_req and d_req same cycle (i_addr=28'h200_0000, d_addr=28'h100_1018), held -> fixed: D served then I; with macro: D then I, then with both re-requesting, I then D.
REQ-031 flush_req during D access -> D completes with d_ack, one IDLE cycle, then flush=1 until cache_ready, flush_ack pulse.
REQ-032 I read at 28'h000_0001, cache_rd=32'hAB00_00BA with cache_ready -> i_rdata=32'hAB00_00BA on i_ack cycle, d_rdata unchanged.
REQ-033 TIMEOUT_CYCLES=8, cache_ready never asserted -> after 8 ACCESS cycles, ACK with arb_timeout=1, d_rdata=0, then IDLE.
REQ-034 rst pulsed in 2nd ACCESS cycle -> all outputs 0 asynchronously, no ack; held d_req re-granted after release.
